// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains a 1-cycle-latency FIFO read port into a circular skid buffer and a valid/ready stream with packet last markers.
// Optional FIFO_RD_STREAM_STATS_EN adds saturating stall/starve cycle counters.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int BUF_DEPTH  = 2,
  parameter int PKT_LEN    = 16
) (
  input  logic                         rd_clk,
  input  logic                         rst_n,
  input  logic                         fifo_empty,
  output logic                         fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]        fifo_dout,
  input  logic                         fifo_valid,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [DATA_WIDTH-1:0]        m_data,
  output logic                         m_last,
  output logic [$clog2(PKT_LEN+1)-1:0] beat_cnt,
  output logic                         rd_err
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [31:0]                  stall_cnt,
  output logic [31:0]                  starve_cnt
`endif
);
  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int BW = $clog2(PKT_LEN + 1);
  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] beat_q, beat_d;
  logic inflight_q, err_q, err_d, first_q, pop, push;
  assign m_valid  = count_q != '0;
  assign m_data   = m_valid ? mem_q[head_q] : '0;
  assign m_last   = m_valid & (beat_q == BW'(PKT_LEN - 1));
  assign beat_cnt = beat_q;
  assign rd_err   = err_q;
  always_comb begin
    pop        = m_valid & m_ready;
    push       = fifo_valid & inflight_q;
    fifo_rd_en = rst_n & ~fifo_empty & ((int'(count_q) + int'(inflight_q) - int'(pop)) < BUF_DEPTH);
    head_d     = pop ? head_q + PW'(1) : head_q;
    tail_d     = push ? tail_q + PW'(1) : tail_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    beat_d     = !pop ? beat_q : (beat_q == BW'(PKT_LEN - 1)) ? '0 : beat_q + BW'(1);
    // a stray strobe right after reset may belong to a read issued before reset
    err_d      = err_q | (fifo_valid & ~inflight_q & ~first_q);
  end
  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
      first_q    <= 1'b1;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      beat_q     <= beat_d;
      inflight_q <= fifo_rd_en;
      err_q      <= err_d;
      first_q    <= 1'b0;
    end
  end
  always_ff @(posedge rd_clk) begin
    if (push) mem_q[tail_q] <= fifo_dout;
  end
`ifdef FIFO_RD_STREAM_STATS_EN
  always_ff @(posedge rd_clk) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      starve_cnt <= '0;
    end else begin
      if (m_valid && !m_ready && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
      if (count_q == '0 && !inflight_q && fifo_empty && starve_cnt != '1) starve_cnt <= starve_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed phases plus random traffic against a queue-based model of the FIFO, skid buffer and packet framing.
module tb_fifo_rd_stream;
  localparam int DW = 32;
  localparam int BD = 2;
  localparam int PL = 16;
  logic rd_clk = 1'b0;
  logic rst_n, fifo_empty, fifo_rd_en, fifo_valid, m_valid, m_ready, m_last, rd_err;
  logic [DW-1:0] fifo_dout, m_data;
  logic [$clog2(PL+1)-1:0] beat_cnt;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [31:0] stall_cnt, starve_cnt;
  longint stall_m, starve_m;
`endif
  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] buf_q[$];
  logic inflight_m, err_m, first_m, inject, nxt_valid;
  logic [DW-1:0] nxt_word, seq;
  int beats, delivered, rd_cnt, last_cnt;

  fifo_rd_stream #(.DATA_WIDTH(DW), .BUF_DEPTH(BD), .PKT_LEN(PL)) dut (
    .rd_clk(rd_clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .fifo_valid(fifo_valid), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .beat_cnt(beat_cnt), .rd_err(rd_err)
`ifdef FIFO_RD_STREAM_STATS_EN
    , .stall_cnt(stall_cnt), .starve_cnt(starve_cnt)
`endif
  );

  always #5 rd_clk = ~rd_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(seq);
      seq = seq + 1;
    end
  endtask

  // one clock: entered and left 1 time unit after a rising edge
  task automatic cycle();
    logic pop_m, exp_rd;
    int occ;
    fifo_empty = (fifo_q.size() == 0);
    @(negedge rd_clk);
    occ    = buf_q.size();
    pop_m  = (occ != 0) && m_ready;
    exp_rd = rst_n && !fifo_empty && ((occ + int'(inflight_m) - int'(pop_m)) < BD);
    chk("rd_en", fifo_rd_en, exp_rd);
    chk("m_valid", m_valid, occ != 0);
    chk("beat_cnt", beat_cnt, beats % PL);
    chk("rd_err", rd_err, err_m);
    chk("occ_le_depth", occ <= BD, 1);
    if (occ != 0) begin
      chk("m_data", m_data, buf_q[0]);
      chk("m_last", m_last, (beats % PL) == PL - 1);
    end else begin
      chk("m_data_idle", m_data, 0);
      chk("m_last_idle", m_last, 0);
    end
`ifdef FIFO_RD_STREAM_STATS_EN
    chk("stall_cnt", stall_cnt, stall_m);
    chk("starve_cnt", starve_cnt, starve_m);
    if (!rst_n) begin
      stall_m = 0;
      starve_m = 0;
    end else begin
      if (occ != 0 && !m_ready) stall_m++;
      if (occ == 0 && !inflight_m && fifo_empty) starve_m++;
    end
`endif
    if (fifo_rd_en) rd_cnt++;
    if (pop_m && m_last) last_cnt++;
    if (!rst_n) begin
      buf_q.delete();
      inflight_m = 0;
      beats = 0;
      err_m = 0;
      first_m = 1;
    end else begin
      if (fifo_valid && inflight_m) buf_q.push_back(fifo_dout);
      if (fifo_valid && !inflight_m && !first_m) err_m = 1;
      if (pop_m) begin
        buf_q.delete(0);
        beats++;
        delivered++;
      end
      inflight_m = exp_rd;
      first_m = 0;
    end
    nxt_valid = 0;
    if (fifo_rd_en && fifo_q.size() != 0) begin
      nxt_valid = 1;
      nxt_word = fifo_q.pop_front();
    end else if (inject) begin
      nxt_valid = 1;
      nxt_word = 32'hDEAD_BEEF;
      inject = 0;
    end
    @(posedge rd_clk);
    #1;
    fifo_valid = nxt_valid;
    fifo_dout = nxt_word;
  endtask

  task automatic drain();
    m_ready = 1;
    for (int i = 0; i < 100 && (fifo_q.size() != 0 || buf_q.size() != 0 || inflight_m || fifo_valid); i++) cycle();
    chk("drained", fifo_q.size() + buf_q.size(), 0);
  endtask

  initial begin
    rst_n = 0; fifo_empty = 1; fifo_valid = 0; fifo_dout = '0; m_ready = 0;
    inject = 0; seq = 32'h1; nxt_word = '0;
    repeat (2) @(posedge rd_clk);
    #1;
    inflight_m = 0; err_m = 0; first_m = 1; beats = 0; delivered = 0; rd_cnt = 0; last_cnt = 0;
`ifdef FIFO_RD_STREAM_STATS_EN
    stall_m = 0; starve_m = 0;
`endif
    rst_n = 1;
    // idle with an empty FIFO
    for (int i = 0; i < 10; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      cycle();
    end
    chk("idle_no_reads", rd_cnt, 0);
    // 32 preloaded words at full rate
    push_words(32);
    m_ready = 1;
    delivered = 0; last_cnt = 0;
    for (int i = 0; i < 40; i++) cycle();
    chk("burst_delivered", delivered, 32);
    chk("burst_lasts", last_cnt, 2);
    // backpressure: only BUF_DEPTH reads while stalled
    push_words(8);
    m_ready = 0; rd_cnt = 0; delivered = 0;
    for (int i = 0; i < 10; i++) cycle();
    chk("stalled_reads", rd_cnt, BD);
    chk("stalled_data", m_data, 32'h21);
    drain();
    chk("stall_release_delivered", delivered, 8);
    // alternating ready with a continuously non-empty FIFO
    delivered = 0;
    push_words(4);
    for (int i = 0; i < 128; i++) begin
      m_ready = (i % 2) == 0;
      if (fifo_q.size() < 4) push_words(2);
      cycle();
    end
    chk("toggle_progress", delivered >= 60, 1);
    drain();
    // reset mid-packet with a full buffer, stray strobe right after reset
    push_words(40);
    m_ready = 1;
    for (int i = 0; i < 40 && (beats % PL) != 5; i++) cycle();
    chk("reached_beat5", beats % PL, 5);
    m_ready = 0;
    for (int i = 0; i < 3; i++) cycle();
    chk("pre_reset_full", buf_q.size(), BD);
    rst_n = 0;
    inject = 1;
    cycle();
    rst_n = 1;
    cycle();
    chk("post_reset_beat", beat_cnt, 0);
    chk("post_reset_no_err", rd_err, 0);
    m_ready = 1; last_cnt = 0; delivered = 0;
    for (int i = 0; i < 22; i++) cycle();
    chk("post_reset_one_last", last_cnt, 1);
    drain();
    // random traffic
    for (int i = 0; i < 400; i++) begin
      m_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) push_words($urandom_range(1, 3));
      cycle();
    end
    drain();
    // stray fifo_valid with nothing in flight
    for (int i = 0; i < 3; i++) cycle();
    inject = 1;
    for (int i = 0; i < 6; i++) cycle();
    chk("rd_err_sticky", rd_err, 1);
    chk("stray_not_buffered", m_valid, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
